// File: rtl/wb_uart_tx.sv
// wb_uart_tx: Wishbone classic slave that queues CPU bytes in a TX FIFO and shifts them out as 8N1 UART frames.
// Define WB_UART_TX_PARITY_EN to add a parity bit (even, or odd when CTRL[2]=1) between data and stop.
module wb_uart_tx #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd433
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [1:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef WB_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [1:0] A_TXDATA  = 2'd0;
    localparam logic [1:0] A_STATUS  = 2'd1;
    localparam logic [1:0] A_DIVISOR = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    logic [7:0]    fifoMem_q [FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ack_q, ack_d, rty_q, rty_d;
    logic [31:0]   rdData_q, rdData_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   divisor_q, divisor_d;
    logic          enable_q, enable_d, irqEn_q, irqEn_d;
    logic [2:0]    state_q, state_d;
    logic [15:0]   baudCnt_q, baudCnt_d;
    logic [2:0]    bitCnt_q, bitCnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic        accept, wrAccept, ctrlWr, pushReq, push, pop;
    logic        full, empty, busy, bitDone, oddParity;
    logic [31:0] regRead;
    logic        unused_ok;

    assign unused_ok = ^{wb_cti_i, wb_bte_i, wb_dat_i[31:16], wb_sel_i[3:2]};

    // A new access is only taken once the previous termination has been seen.
    assign accept   = wb_cyc_i & wb_stb_i & ~(ack_q | rty_q);
    assign wrAccept = accept & wb_we_i;
    assign ctrlWr   = wrAccept & (wb_adr_i == A_CTRL) & wb_sel_i[0];
    assign full     = (level_q == LEVEL_FULL);
    assign empty    = (level_q == '0);
    assign busy     = (state_q != S_IDLE);
    assign pushReq  = wrAccept & (wb_adr_i == A_TXDATA) & wb_sel_i[0];
    assign push     = pushReq & ~full;
    assign pop      = (state_q == S_IDLE) & enable_q & ~empty;
    assign bitDone  = (baudCnt_q == '0);

`ifdef WB_UART_TX_PARITY_EN
    logic oddParity_q, parityBit_q;

    // Parity is fixed when the byte is popped so a CTRL write mid-frame cannot corrupt it.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            oddParity_q <= 1'b0;
            parityBit_q <= 1'b0;
        end else begin
            if (ctrlWr) oddParity_q <= wb_dat_i[2];
            if (pop) parityBit_q <= (^fifoMem_q[rdPtr_q]) ^ oddParity_q;
        end
    end
    assign oddParity = oddParity_q;
`else
    assign oddParity = 1'b0;
`endif

    always_comb begin
        regRead = '0;
        case (wb_adr_i)
            A_STATUS:  regRead = {16'd0, 8'(level_q), 4'd0, overflow_q, empty, full, busy};
            A_DIVISOR: regRead = {16'd0, divisor_q};
            A_CTRL:    regRead = {29'd0, oddParity, irqEn_q, enable_q};
            default:   regRead = '0;
        endcase
    end

    always_comb begin
        ack_d      = 1'b0;
        rty_d      = 1'b0;
        rdData_d   = '0;
        overflow_d = overflow_q;
        divisor_d  = divisor_q;
        enable_d   = enable_q;
        irqEn_d    = irqEn_q;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        if (accept) begin
            if (pushReq && full) begin
                rty_d      = 1'b1;
                overflow_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (!wb_we_i) rdData_d = regRead;
            end
        end
        if (wrAccept && (wb_adr_i == A_STATUS) && wb_sel_i[0] && wb_dat_i[3]) overflow_d = 1'b0;
        if (wrAccept && (wb_adr_i == A_DIVISOR)) begin
            if (wb_sel_i[0]) divisor_d[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) divisor_d[15:8] = wb_dat_i[15:8];
        end
        if (ctrlWr) begin
            enable_d = wb_dat_i[0];
            irqEn_d  = wb_dat_i[1];
        end
        if (push) wrPtr_d = wrPtr_q + 1'b1;
        if (pop)  rdPtr_d = rdPtr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // Every bit boundary reloads the baud counter from the live DIVISOR value.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitCnt_d  = bitCnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = fifoMem_q[rdPtr_q];
                    baudCnt_d = divisor_q;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bitDone) begin
                    baudCnt_d = divisor_q;
                    bitCnt_d  = 3'd0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bitDone) begin
                    baudCnt_d = divisor_q;
                    if (bitCnt_q == 3'd7) begin
`ifdef WB_UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parityBit_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bitCnt_d = bitCnt_q + 1'b1;
                        shift_d  = {1'b0, shift_q[7:1]};
                        tx_d     = shift_q[1];
                    end
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
`ifdef WB_UART_TX_PARITY_EN
            S_PARITY: begin
                if (bitDone) begin
                    baudCnt_d = divisor_q;
                    state_d   = S_STOP;
                    tx_d      = 1'b1;
                end else begin
                    baudCnt_d = baudCnt_q - 1'b1;
                end
            end
`endif
            S_STOP: begin
                tx_d = 1'b1;
                if (bitDone) state_d = S_IDLE;
                else         baudCnt_d = baudCnt_q - 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (push) fifoMem_q[wrPtr_q] <= wb_dat_i[7:0];
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            ack_q      <= 1'b0;
            rty_q      <= 1'b0;
            rdData_q   <= '0;
            overflow_q <= 1'b0;
            divisor_q  <= DIV_RESET;
            enable_q   <= 1'b0;
            irqEn_q    <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            state_q    <= S_IDLE;
            baudCnt_q  <= '0;
            bitCnt_q   <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            ack_q      <= ack_d;
            rty_q      <= rty_d;
            rdData_q   <= rdData_d;
            overflow_q <= overflow_d;
            divisor_q  <= divisor_d;
            enable_q   <= enable_d;
            irqEn_q    <= irqEn_d;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            state_q    <= state_d;
            baudCnt_q  <= baudCnt_d;
            bitCnt_q   <= bitCnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    assign wb_ack_o = ack_q;
    assign wb_rty_o = rty_q;
    assign wb_err_o = 1'b0;
    assign wb_dat_o = rdData_q;
    assign tx_o     = tx_q;
    assign irq_o    = irqEn_q & empty & ~busy;

endmodule

// File: tb/tb_wb_uart_tx.sv
// tb_wb_uart_tx: directed bench for wb_uart_tx with hand-computed frames, FIFO limits and reset behaviour.
// Follows the DUT build: the parity scenario is selected by WB_UART_TX_PARITY_EN.
module tb_wb_uart_tx;

    logic        wb_clk;
    logic        wb_rst;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic        tx_o;
    logic        irq_o;

    int   vectors;
    int   miscompares;
    logic txLog  [0:127];
    logic irqLog [0:127];

    wb_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd433)) dut (
        .wb_clk   (wb_clk),
        .wb_rst   (wb_rst),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_sel_i (wb_sel_i),
        .wb_we_i  (wb_we_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_cti_i (wb_cti_i),
        .wb_bte_i (wb_bte_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .wb_err_o (wb_err_o),
        .wb_rty_o (wb_rty_o),
        .tx_o     (tx_o),
        .irq_o    (irq_o)
    );

    always #5 wb_clk = ~wb_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Holds stb until a termination arrives, then releases the bus just after that edge.
    task automatic busAccess(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic ack, output logic rty,
                             output logic [31:0] rdata);
        int n;
        @(negedge wb_clk);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        n = 0;
        while (n < 8) begin
            @(posedge wb_clk); #1;
            if (wb_ack_o || wb_rty_o || wb_err_o) break;
            n++;
        end
        if (n == 8) begin
            vectors++; miscompares++;
            $display("[TB] FAIL bus_timeout adr=%0d: no termination seen, required one within 8 cycles", adr);
        end
        ack = wb_ack_o; rty = wb_rty_o; rdata = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic busWrite(input logic [1:0] adr, input logic [31:0] dat);
        logic a, r;
        logic [31:0] d;
        busAccess(1'b1, adr, dat, 4'hF, a, r, d);
    endtask

    task automatic busRead(input logic [1:0] adr, output logic [31:0] rdata);
        logic a, r;
        busAccess(1'b0, adr, 32'd0, 4'hF, a, r, rdata);
    endtask

    task automatic captureTx(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge wb_clk); #1;
            txLog[i]  = tx_o;
            irqLog[i] = irq_o;
        end
    endtask

    task automatic resetDut();
        @(negedge wb_clk);
        wb_rst = 1'b1;
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #2 wb_rst = 1'b1;
        #1;
        vectors++;
        if ({tx_o, irq_o, wb_ack_o, wb_err_o, wb_rty_o} !== 5'b10000 || wb_dat_o !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got tx/irq/ack/err/rty=%b dat=%h, expected 10000 dat=0",
                     {tx_o, irq_o, wb_ack_o, wb_err_o, wb_rty_o}, wb_dat_o);
        end
        resetDut();
        busRead(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin miscompares++; $display("[TB] FAIL reset_status: got %h, expected 00000004", rd); end
        busRead(2'd2, rd);
        vectors++;
        if (rd !== 32'd433) begin miscompares++; $display("[TB] FAIL reset_divisor: got %0d, expected 433", rd); end
        busRead(2'd3, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %h, expected 0", rd); end
        vectors++;
        if (irq_o !== 1'b0 || tx_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL reset_idle_lines: got irq=%b tx=%b, expected irq=0 tx=1", irq_o, tx_o);
        end
    endtask

    task automatic test_tx_frame();
        logic [31:0] rd;
        logic [9:0]  frameBits;
        logic        bad;
        frameBits = {1'b1, 8'hA5, 1'b0};
        busWrite(2'd2, 32'd3);
        busWrite(2'd3, 32'd1);
        busWrite(2'd0, 32'hA5);
        fork
            captureTx(44);
            begin
                repeat (10) @(posedge wb_clk);
                busRead(2'd1, rd);
                vectors++;
                if (rd !== 32'h0000_0005) begin
                    miscompares++; $display("[TB] FAIL frame_status_busy: got %h, expected 00000005", rd);
                end
            end
        join
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int k = 0; k < 4; k++) if (txLog[b*4+k] !== frameBits[b]) bad = 1'b1;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL frame_a5_bit%0d: got %b%b%b%b, expected four cycles of %b", b,
                         txLog[b*4], txLog[b*4+1], txLog[b*4+2], txLog[b*4+3], frameBits[b]);
            end
        end
        vectors++;
        if ({txLog[40], txLog[41], txLog[42], txLog[43]} !== 4'b1111) begin
            miscompares++; $display("[TB] FAIL frame_a5_idle: got %b%b%b%b, expected 1111",
                                    txLog[40], txLog[41], txLog[42], txLog[43]);
        end
        busRead(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin miscompares++; $display("[TB] FAIL frame_status_done: got %h, expected 00000004", rd); end
    endtask

    task automatic test_fifo_full();
        logic        a, r;
        logic [31:0] d, rd;
        busWrite(2'd3, 32'd0);
        for (int i = 0; i < 9; i++) begin
            busAccess(1'b1, 2'd0, 32'(i + 16), 4'h1, a, r, d);
            vectors++;
            if ({a, r} !== ((i < 8) ? 2'b10 : 2'b01)) begin
                miscompares++; $display("[TB] FAIL fifo_push%0d: got ack=%b rty=%b, expected %s", i, a, r,
                                        (i < 8) ? "ack" : "rty");
            end
        end
        busRead(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_080A) begin miscompares++; $display("[TB] FAIL fifo_full_status: got %h, expected 0000080a", rd); end
        busWrite(2'd1, 32'h8);
        busRead(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0802) begin miscompares++; $display("[TB] FAIL overflow_clear: got %h, expected 00000802", rd); end
        busRead(2'd0, rd);
        vectors++;
        if (rd !== 32'd0) begin miscompares++; $display("[TB] FAIL txdata_read: got %h, expected 0", rd); end
        busAccess(1'b1, 2'd0, 32'h77, 4'hE, a, r, d);
        busRead(2'd1, rd);
        vectors++;
        if ({a, r} !== 2'b10 || rd !== 32'h0000_0802) begin
            miscompares++; $display("[TB] FAIL nosel_write: got ack=%b rty=%b status=%h, expected ack=1 rty=0 status=00000802", a, r, rd);
        end
        resetDut();
    endtask

    task automatic test_back_to_back();
        logic [23:0] expSeq;
        logic [23:0] gotSeq;
        expSeq = {3'b111, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0};
        resetDut();
        busWrite(2'd2, 32'd0);
        busWrite(2'd3, 32'd3);
        vectors++;
        if (irq_o !== 1'b1) begin miscompares++; $display("[TB] FAIL irq_idle_empty: got %b, expected 1", irq_o); end
        busWrite(2'd0, 32'h00);
        fork
            captureTx(24);
            busWrite(2'd0, 32'h0F);
        join
        for (int i = 0; i < 24; i++) gotSeq[i] = txLog[i];
        vectors++;
        if (gotSeq !== expSeq) begin
            miscompares++; $display("[TB] FAIL back_to_back_seq: got %b, expected %b (lsb first in time)", gotSeq, expSeq);
        end
        vectors++;
        if ({irqLog[10], irqLog[20], irqLog[21]} !== 3'b001) begin
            miscompares++; $display("[TB] FAIL irq_timing: got gap/stop/after=%b%b%b, expected 001",
                                    irqLog[10], irqLog[20], irqLog[21]);
        end
    endtask

    task automatic test_divisor_change();
        int   bitVal [10];
        int   dur    [10];
        int   idx;
        logic bad;
        bitVal = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        dur    = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8};
        resetDut();
        busWrite(2'd2, 32'd3);
        busWrite(2'd3, 32'd1);
        busWrite(2'd0, 32'h55);
        fork
            captureTx(66);
            begin
                repeat (13) @(posedge wb_clk);
                busWrite(2'd2, 32'd7);
            end
        join
        idx = 0;
        for (int b = 0; b < 10; b++) begin
            bad = 1'b0;
            for (int k = 0; k < dur[b]; k++) begin
                if (txLog[idx] !== bitVal[b][0]) bad = 1'b1;
                idx++;
            end
            vectors++;
            if (bad) begin
                miscompares++; $display("[TB] FAIL divchange_seg%0d: tx differs in cycles %0d..%0d, expected %0d for %0d cycles",
                                        b, idx - dur[b], idx - 1, bitVal[b], dur[b]);
            end
        end
        vectors++;
        if ({txLog[64], txLog[65]} !== 2'b11) begin
            miscompares++; $display("[TB] FAIL divchange_idle: got %b%b, expected 11", txLog[64], txLog[65]);
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        resetDut();
        busWrite(2'd2, 32'd3);
        busWrite(2'd3, 32'd1);
        busWrite(2'd0, 32'h00);
        busWrite(2'd0, 32'h00);
        busWrite(2'd0, 32'h00);
        repeat (4) @(posedge wb_clk);
        #1;
        vectors++;
        if (tx_o !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_data: got tx=%b, expected 0", tx_o); end
        #2 wb_rst = 1'b1;
        #1;
        vectors++;
        if (tx_o !== 1'b1) begin miscompares++; $display("[TB] FAIL async_reset_tx: got tx=%b, expected 1", tx_o); end
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst = 1'b0;
        busRead(2'd1, rd);
        vectors++;
        if (rd !== 32'h0000_0004) begin miscompares++; $display("[TB] FAIL midreset_status: got %h, expected 00000004", rd); end
        busRead(2'd2, rd);
        vectors++;
        if (rd !== 32'd433) begin miscompares++; $display("[TB] FAIL midreset_divisor: got %0d, expected 433", rd); end
        captureTx(20);
        vectors++;
        if (txLog[0] !== 1'b1 || txLog[19] !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midreset_quiet: got tx=%b/%b, expected 1/1", txLog[0], txLog[19]);
        end
    endtask

`ifdef WB_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [31:0] rd;
        logic [11:0] expSeq;
        logic [11:0] gotSeq;
        expSeq = {1'b1, 1'b1, 1'b0, 8'h01, 1'b0};
        resetDut();
        busWrite(2'd2, 32'd0);
        busWrite(2'd3, 32'd5);
        busRead(2'd3, rd);
        vectors++;
        if (rd !== 32'd5) begin miscompares++; $display("[TB] FAIL parity_ctrl: got %h, expected 5", rd); end
        busWrite(2'd0, 32'h01);
        captureTx(12);
        for (int i = 0; i < 12; i++) gotSeq[i] = txLog[i];
        vectors++;
        if (gotSeq !== expSeq) begin
            miscompares++; $display("[TB] FAIL parity_frame: got %b, expected %b (lsb first in time)", gotSeq, expSeq);
        end
    endtask
`else
    task automatic test_parity();
        logic [31:0] rd;
        logic [10:0] expSeq;
        logic [10:0] gotSeq;
        expSeq = {1'b1, 1'b1, 8'h01, 1'b0};
        resetDut();
        busWrite(2'd2, 32'd0);
        busWrite(2'd3, 32'd5);
        busRead(2'd3, rd);
        vectors++;
        if (rd !== 32'd1) begin miscompares++; $display("[TB] FAIL noparity_ctrl: got %h, expected 1", rd); end
        busWrite(2'd0, 32'h01);
        captureTx(11);
        for (int i = 0; i < 11; i++) gotSeq[i] = txLog[i];
        vectors++;
        if (gotSeq !== expSeq) begin
            miscompares++; $display("[TB] FAIL noparity_frame: got %b, expected %b (lsb first in time)", gotSeq, expSeq);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        wb_clk   = 1'b0;
        wb_rst   = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_cti_i = '0;
        wb_bte_i = '0;
        $display("[TB] starting wb_uart_tx directed tests");
        test_reset();
        test_tx_frame();
        test_fifo_full();
        test_back_to_back();
        test_divisor_change();
        test_reset_midframe();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx.md
# wb_uart_tx

Wishbone classic slave (responder) that serialises bytes written by the CPU data bus master into an 8N1 UART stream. It sits on the data bus beside the GPIO and RAM slaves: the CPU pushes bytes into a small FIFO, and a baud-rate-timed shifter drains them onto `tx_o`. It also provides a status register and a "transmitter drained" interrupt.

## Interface
Clock is `wb_clk`. Reset is `wb_rst`: asynchronous, active-high.

Parameters:
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two, ≥2.
- `DIV_RESET`, default 16'd433: reset value of DIVISOR (115200 baud at 50 MHz).

Ports:
- `wb_clk` in 1: bus and logic clock.
- `wb_rst` in 1: asynchronous active-high reset.
- `wb_adr_i` in 2: word register index.
- `wb_dat_i` in 32: write data.
- `wb_sel_i` in 4: byte enables.
- `wb_we_i` in 1: write strobe.
- `wb_cyc_i` in 1: bus cycle.
- `wb_stb_i` in 1: strobe.
- `wb_cti_i` in 3: ignored; every access is treated as classic.
- `wb_bte_i` in 2: ignored.
- `wb_dat_o` out 32: read data, valid while `wb_ack_o` is high.
- `wb_ack_o` out 1: normal termination.
- `wb_err_o` out 1: error termination.
- `wb_rty_o` out 1: retry termination.
- `tx_o` out 1: serial output, idles high.
- `irq_o` out 1: level interrupt.

## Operation
Register map:
- **0 TXDATA (W)**
  - Write with `sel[0]` pushes `dat_i[7:0]`.
  - Push while FIFO full → terminate with `wb_rty_o` instead of `wb_ack_o`; no push.
  - Write with `sel[0]`=0 → ack, no push.
  - Reads return 0.
- **1 STATUS (RO)**
  - [0] busy: FSM not IDLE.
  - [1] full.
  - [2] empty.
  - [3] overflow: sticky; set on any retried push; cleared by writing 1 to STATUS[3].
  - [15:8] FIFO level.
  - Other writes ignored.
- **2 DIVISOR (RW)**, bits [15:0]: bit period = DIVISOR+1 clocks. Upper bits read 0.
- **3 CTRL (RW)**
  - [0] enable.
  - [1] irq_en.
  - [2] odd parity; see Configuration.
  - Others read 0.

Bus responder:
- An access is accepted on a clock edge where `cyc & stb & !(ack|err|rty)`.
- On that edge, exactly one of ack/err/rty is registered high for one cycle, and any write side effect occurs.
- Continuous `stb` therefore yields one termination every 2 cycles.
- `wb_err_o` is never asserted (all four indices are decoded).
- Dropping `cyc` in the termination cycle is legal and has no effect.

TX FSM states:
- **IDLE**: `tx_o`=1. If enable=1 and FIFO not empty: pop, load shifter, load baud counter with DIVISOR, go to START.
- **START**: `tx_o`=0 for one bit period, then DATA.
- **DATA**: 8 bits, LSB first, one bit period each. Bit counter 0..7; after bit 7, go to PARITY (if compiled in) or STOP.
- **STOP**: `tx_o`=1 for one bit period, then IDLE.
  - IDLE is always occupied for at least one cycle between frames.

Baud counter:
- Down-counter, reloaded from DIVISOR at every bit boundary.
- A DIVISOR write mid-frame takes effect at the next bit boundary.

`irq_o` = irq_en & empty & !busy (combinational from registers).

Boundary rules:
- Push and pop on the same edge while full: the push is judged against the pre-edge full flag, so it is retried. The pop proceeds and the level decrements.
- Push into an empty FIFO on the same edge the FSM samples IDLE: no pop that edge; the pop occurs on the next edge.
- Clearing enable mid-frame: the current frame completes, then no further pops.
- FIFO pointers wrap modulo FIFO_DEPTH. The level counter is log2(FIFO_DEPTH)+1 bits wide.
- Reset at any time asynchronously returns everything to reset values, with `tx_o`=1 immediately. FIFO contents are discarded.

## Timing
Reset values:
- `wb_ack_o`/`wb_err_o`/`wb_rty_o` = 0.
- `wb_dat_o` = 0.
- `tx_o` = 1.
- `irq_o` = 0.
- FSM in IDLE; FIFO empty.
- DIVISOR = DIV_RESET; CTRL = 0.

Latency and frame length:
- Termination is registered, appearing 1 cycle after `stb` is first sampled.
- `tx_o` falls on the first edge after the TXDATA ack cycle begins, provided enable=1 and the FSM is in IDLE.
- Frame length is 10 bit periods (11 with parity), plus 1 idle cycle.
- `tx_o` is driven directly from a flop.

## Configuration
- `WB_UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP, lasting one bit period.
  - Parity bit = XOR of the data bits, inverted when CTRL[2]=1 (odd parity).
  - CTRL[2] is read/write.
- Undefined:
  - No PARITY state; frame is 8N1.
  - CTRL[2] reads 0 and writes are ignored.

## Test plan
- Reset → `tx_o`=1, STATUS=0x0000_0004, DIVISOR reads 433, CTRL reads 0, `irq_o`=0.
- DIVISOR=3, CTRL=1, write TXDATA 0xA5 → `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each bit held exactly 4 cycles. busy=1 throughout, then 0.
- CTRL=0, write 9 bytes with FIFO_DEPTH=8 → 8 acks, 9th gets `wb_rty_o`. STATUS = full=1, level=8, overflow=1. Writing STATUS 0x8 clears overflow.
- CTRL=3, DIVISOR=0, push 2 bytes → back-to-back frames separated by exactly 1 idle cycle. `irq_o` rises one cycle after the second STOP ends.
- DIVISOR=3, write DIVISOR=7 in the middle of data bit 2 → bit 2 remains 4 cycles; bit 3 onward last 8 cycles.
- Assert `wb_rst` during DATA → `tx_o`=1 asynchronously, FIFO empty. With parity compiled in, CTRL=5, byte 0x01: parity bit = 0.
